// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer and its helpers.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DEF_STABLE_TICKS = 3;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous input.
// The output is the oldest stage; SYNC_STAGES must be 2 or more.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  // Shift the raw input one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  // Chain register, cleared by reset so the debouncer starts from a known level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/tick_debouncer.sv
// Tick-paced debouncer for one mechanical switch input.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LOW       | output 0, synchronized input agrees
// WAIT_HIGH | output 0, input went high; counting ticks of stable high
// HIGH      | output 1, synchronized input agrees
// WAIT_LOW  | output 1, input went low; counting ticks of stable low
//
// A level change inside a WAIT state aborts back to the settled state, and
// the abort wins over a tick arriving in the same cycle. The first tick after
// entering WAIT may come after a partial period, so the effective stable time
// lies between STABLE_TICKS-1 and STABLE_TICKS tick periods.
module tick_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_in,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic       sw_s;
  db_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (sw_in),
    .q  (sw_s)
  );

  // Next-state, counter and output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        level_d = 1'b0;
        if (sw_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sw_s) begin
          state_d = LOW;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HIGH: begin
        level_d = 1'b1;
        if (!sw_s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sw_s) begin
          state_d = HIGH;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = LOW;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_level = level_q;
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;

endmodule

// File: tb/tb_tick_debouncer.sv
// Bench for tick_debouncer: two instances (3-tick and 1-tick windows) share
// stimulus and are compared every cycle against a behavioural model.
module tb_tick_debouncer;

  logic clk, rst, tick, sw_in;
  logic lvl3, rise3, fall3;
  logic lvl1, rise1, fall1;

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;

  tick_debouncer #(.STABLE_TICKS(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst(rst), .tick(tick), .sw_in(sw_in),
    .db_level(lvl3), .db_rise(rise3), .db_fall(fall3)
  );

  tick_debouncer #(.STABLE_TICKS(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .sw_in(sw_in),
    .db_level(lvl1), .db_rise(rise1), .db_fall(fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the synchronized input is sw_in from two edges ago
  // (zero right after reset). A change of level is accepted once N ticks
  // have been seen while the input kept disagreeing with the output, not
  // counting a tick on the very edge where the disagreement first appeared.
  bit m_lvl[2], m_pend[2], m_rise[2], m_fall[2];
  int m_run[2];
  int nt[2] = '{3, 1};
  bit hist0 = 1'b0, hist1 = 1'b0;
  logic [5:0] exp_v;
  wire  [5:0] obs = {lvl3, rise3, fall3, lvl1, rise1, fall1};

  always @(posedge clk) begin
    bit s;
    s = hist1;
    if (rst) begin
      hist0 = 1'b0;
      hist1 = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_lvl[m] = 1'b0; m_pend[m] = 1'b0; m_run[m] = 0;
        m_rise[m] = 1'b0; m_fall[m] = 1'b0;
      end
    end else begin
      hist1 = hist0;
      hist0 = sw_in;
      for (int m = 0; m < 2; m++) begin
        m_rise[m] = 1'b0;
        m_fall[m] = 1'b0;
        if (s == m_lvl[m]) begin
          m_pend[m] = 1'b0;
          m_run[m]  = 0;
        end else if (!m_pend[m]) begin
          m_pend[m] = 1'b1;
          m_run[m]  = 0;
        end else if (tick) begin
          m_run[m] = m_run[m] + 1;
          if (m_run[m] == nt[m]) begin
            m_lvl[m]  = ~m_lvl[m];
            m_rise[m] = m_lvl[m];
            m_fall[m] = ~m_lvl[m];
            m_pend[m] = 1'b0;
            m_run[m]  = 0;
          end
        end
      end
    end
  end

  always_comb exp_v = {m_lvl[0], m_rise[0], m_fall[0], m_lvl[1], m_rise[1], m_fall[1]};

  // Drive one cycle of stimulus; tick fires on every 4th cycle.
  task automatic drive(input logic sw, input logic r);
    @(negedge clk);
    sw_in = sw;
    rst   = r;
    tick  = (phase == 3);
    phase = (phase + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      n_cmp++;
      if ({lvl3, rise3, fall3, lvl1, rise1, fall1} !== 6'b0) begin
        n_err++; $display("FAIL reset_outputs got=%b want=000000", obs);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL reset_idle got=%b want=%b", obs, exp_v); end
    end
    n_cmp++;
    if ({lvl3, lvl1} !== 2'b01) begin
      n_err++; $display("FAIL reset_single_tick lvl3/lvl1 got=%b%b want=01", lvl3, lvl1);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL reset_requal got=%b want=%b", obs, exp_v); end
    end
    n_cmp++;
    if (lvl3 !== 1'b1) begin n_err++; $display("FAIL reset_final_level got=%b want=1", lvl3); end
  endtask

  task automatic test_edge(input logic sw, input string name);
    int rc = 0, fc = 0;
    for (int i = 0; i < 24; i++) begin
      drive(sw, 1'b0);
      if (rise3) rc++;
      if (fall3) fc++;
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL %s_cycle got=%b want=%b", name, obs, exp_v); end
    end
    n_cmp++;
    if ({lvl3, rc[1:0], fc[1:0]} !== {sw, sw ? 2'd1 : 2'd0, sw ? 2'd0 : 2'd1}) begin
      n_err++;
      $display("FAIL %s_pulses level=%b rises=%0d falls=%0d want level=%b one pulse", name, lvl3, rc, fc, sw);
    end
  endtask

  // Hold sw_in high until the 3-tick model has counted two ticks in WAIT.
  task automatic wait_two_ticks(input string name);
    int k = 0;
    while (!(m_pend[0] && m_run[0] == 2) && k < 40) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL %s_pre got=%b want=%b", name, obs, exp_v); end
      k++;
    end
    n_cmp++;
    if (k >= 40) begin n_err++; $display("FAIL %s_timeout got=%0d cycles want <40", name, k); end
  endtask

  task automatic test_bounce();
    wait_two_ticks("bounce");
    drive(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (lvl3 !== 1'b0 || rise3 !== 1'b0 || obs !== exp_v) begin
        n_err++; $display("FAIL bounce_hold got=%b want=%b (lvl3 0)", obs, exp_v);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL bounce_repress got=%b want=%b", obs, exp_v); end
    end
    n_cmp++;
    if (lvl3 !== 1'b1) begin n_err++; $display("FAIL bounce_final got=%b want=1", lvl3); end
  endtask

  task automatic test_collision();
    wait_two_ticks("collide");
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_cmp++;
    if ({lvl3, rise3, fall3} !== 3'b000 || obs !== exp_v) begin
      n_err++; $display("FAIL collide_abort got=%b want=%b (dut3 000)", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    wait_two_ticks("midrst");
    drive(1'b1, 1'b1);
    n_cmp++;
    if (obs !== 6'b0) begin n_err++; $display("FAIL midrst_clear got=%b want=000000", obs); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (lvl3 !== 1'b0 || obs !== exp_v) begin
        n_err++; $display("FAIL midrst_hold got=%b want=%b (lvl3 0)", obs, exp_v);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL midrst_requal got=%b want=%b", obs, exp_v); end
    end
    n_cmp++;
    if (lvl3 !== 1'b1) begin n_err++; $display("FAIL midrst_final got=%b want=1", lvl3); end
  endtask

  task automatic test_random();
    int left = 0;
    logic v = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (left == 0) begin
        v    = $urandom_range(0, 1);
        left = $urandom_range(1, 18);
      end
      left--;
      drive(v, ($urandom_range(0, 59) == 0));
      n_cmp++;
      if (obs !== exp_v || (rise3 & fall3) || (rise1 & fall1)) begin
        n_err++; $display("FAIL random_cycle%0d got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sw_in = 1'b0; tick = 1'b0;
    test_reset();
    test_edge(1'b0, "release");
    test_edge(1'b1, "press");
    test_edge(1'b0, "release2");
    test_bounce();
    test_edge(1'b0, "release3");
    test_collision();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- FSM debouncer for one mechanical input (switch/button). Sits directly downstream of clk_divider and consumes its one-cycle `tick` strobe as the sampling time base.
- Synchronizes the raw input and requires STABLE_TICKS consecutive ticks of a stable level before it changes the debounced output.
- Emits a registered debounced level plus one-cycle rise and fall pulses for downstream control logic.

Parameters:
- STABLE_TICKS, 3: number of consecutive `tick` strobes the synchronized input must hold before the output changes. Legal range is 1 or more.
- SYNC_STAGES, 2: depth of the input synchronizer flop chain. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide sampling strobe from clk_divider.
- sw_in  input  1  raw asynchronous switch input.
- db_level  output  1  debounced level, registered.
- db_rise  output  1  one-cycle pulse on the 0->1 transition of db_level.
- db_fall  output  1  one-cycle pulse on the 1->0 transition of db_level.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All flops update only on posedge clk.
- Reset values: sync chain all 0, state = LOW, cnt = 0, db_level = 0, db_rise = 0, db_fall = 0.
- Synchronizer: sw_in passes through SYNC_STAGES flops to give sw_s. This adds SYNC_STAGES cycles of latency and needs no tick.
- Counter: cnt width is max(1, $clog2(STABLE_TICKS)). It only increments inside the WAIT states.
- State LOW (db_level = 0):
  - sw_s = 1 -> go to WAIT_HIGH with cnt <= 0.
  - Otherwise stay. tick is ignored.
- State WAIT_HIGH (db_level = 0):
  - sw_s = 0 -> go to LOW. This is glitch abort and takes priority over tick in the same cycle.
  - Else tick = 1 and cnt == STABLE_TICKS-1 -> go to HIGH, db_level <= 1, db_rise <= 1.
  - Else tick = 1 -> cnt <= cnt+1.
- State HIGH (db_level = 1): symmetric to LOW. sw_s = 0 -> go to WAIT_LOW with cnt <= 0.
- State WAIT_LOW (db_level = 1): symmetric to WAIT_HIGH.
  - sw_s = 1 -> go to HIGH. Abort has priority over tick.
  - On the qualifying tick -> go to LOW, db_level <= 0, db_fall <= 1.
- Output timing:
  - db_level changes on the clk edge that samples the qualifying tick, so it is visible 1 cycle after that tick.
  - db_rise/db_fall are high for exactly that same cycle, then return to 0.
  - db_rise and db_fall are never high together.
- Debounce window:
  - The first tick after entering WAIT may arrive after a partial period, so the effective stable time is between (STABLE_TICKS-1) and STABLE_TICKS tick periods.
  - STABLE_TICKS = 1: the first tick in WAIT commits the change.
- tick asserted on consecutive cycles is legal; each high cycle counts as one tick.
- Reset mid-WAIT discards the partial count. The block returns to LOW with db_level = 0 even if sw_in is held high, then re-qualifies from scratch.
- An unreachable state encoding decodes to LOW.

Decomposition:
- Shared package debounce_pkg holds:
  - typedef enum logic [1:0] db_state_t {LOW, WAIT_HIGH, HIGH, WAIT_LOW};
  - localparam DEF_STABLE_TICKS = 3.
- Sub-module sync_ff_chain, parameterized by SYNC_STAGES, with rst clearing it. It is reusable for other async inputs.
- FSM, counter and output registers stay in tick_debouncer.

Test Plan:
- Bench config: STABLE_TICKS = 3, tick driven every 4th cycle.
- Reset then idle: rst high 3 cycles with sw_in = 1 -> db_level = 0, no pulses; db_level rises only after 3 ticks post-reset.
- Clean press: sw_in 0->1 and held -> db_level = 1 one cycle after the 3rd tick following sw_s = 1; db_rise high for exactly 1 cycle; db_fall stays 0.
- Bounce abort: sw_in high across 2 ticks, then low for 1 cycle before the 3rd tick -> stays in LOW, db_level stays 0, no db_rise; re-press must again need 3 full ticks.
- Abort/tick collision: sw_s drops on the same cycle as the qualifying tick -> state LOW, db_level = 0, no pulse.
- Release: from HIGH, sw_in 1->0 held -> db_level = 0 one cycle after the 3rd tick; db_fall single-cycle pulse.
- Reset mid-WAIT: rst asserted after 2 ticks in WAIT_HIGH -> next cycle all outputs 0, cnt = 0; 3 new ticks are required. Also re-run with STABLE_TICKS = 1: the first tick commits the change.
